// File: rtl/main_ctrl_mc.sv
// Multi-channel main controller: memory init, R/Co table load, interleaved sample
// intake with per-channel zero-sleep, soft input clear and sticky load-error flag.
module main_ctrl_mc #(
    parameter int N_CH       = 2,
    parameter int R_DEPTH    = 16,
    parameter int CO_DEPTH   = 512,
    parameter int IN_DEPTH   = 256,
    parameter int ZERO_LIMIT = 800,
    parameter int AW         = 10,
    parameter int CW         = 1
) (
    input  logic            Sclk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic            Frame_sync,
    input  logic            in_data_ready,
    input  logic [N_CH-1:0] all_zero,
    input  logic            clear_req,
    output logic            InReady,
    output logic            ALU_calc,
    output logic [CW-1:0]   alu_ch,
    output logic            mem_clear_data,
    output logic            mem_R_en,
    output logic            mem_Co_en,
    output logic            mem_In_en,
    output logic            mem_r0w1,
    output logic [AW-1:0]   mem_addr,
    output logic [N_CH-1:0] sleep,
    output logic            load_err
);

    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    localparam logic [AW-1:0] CO_LAST = AW'(N_CH * CO_DEPTH - 1);
    localparam logic [AW-1:0] R_LAST  = AW'(N_CH * R_DEPTH - 1);
    localparam logic [AW-1:0] IN_LAST = AW'(N_CH * IN_DEPTH - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);
    localparam logic [ZW-1:0] Z_MAX   = ZW'(ZERO_LIMIT);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_R, S_READ_R, S_WAIT_CO,
        S_READ_CO, S_WAIT_IN, S_WORK, S_CLEAR
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr, addr_nxt;
    logic [CW-1:0]   ch_ptr;
    logic [ZW-1:0]   zcnt [N_CH];
    logic            in_d;
    logic            pulse;
    logic            pulse_work;
    logic            cur_zero;
    logic            cur_sleep;
    logic            abort;
    logic            clr_ch;

    assign pulse      = in_data_ready & ~in_d;
    assign pulse_work = pulse & (state == S_WORK);
    assign cur_zero   = all_zero[ch_ptr];
    assign cur_sleep  = sleep[ch_ptr];
    assign mem_addr   = addr;

    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        abort          = 1'b0;
        clr_ch         = 1'b0;
        InReady        = 1'b0;
        ALU_calc       = 1'b0;
        alu_ch         = '0;
        mem_clear_data = 1'b0;
        mem_R_en       = 1'b0;
        mem_Co_en      = 1'b0;
        mem_In_en      = 1'b0;
        mem_r0w1       = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_INIT: begin
                {mem_R_en, mem_Co_en, mem_In_en} = 3'b111;
                mem_r0w1       = 1'b1;
                mem_clear_data = 1'b1;
                if (addr == CO_LAST) begin
                    state_nxt = S_WAIT_R;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            S_WAIT_R, S_WAIT_CO: begin
                InReady  = 1'b1;
                addr_nxt = '0;
                if (Frame_sync)
                    state_nxt = (state == S_WAIT_R) ? S_READ_R : S_READ_CO;
            end
            S_READ_R, S_READ_CO: begin
                InReady = 1'b1;
                if (Frame_sync) begin
                    abort     = 1'b1;
                    addr_nxt  = '0;
                    state_nxt = S_WAIT_R;
                end else if (pulse) begin
                    mem_R_en  = (state == S_READ_R);
                    mem_Co_en = (state == S_READ_CO);
                    mem_r0w1  = 1'b1;
                    if ((state == S_READ_R && addr == R_LAST) ||
                        (state == S_READ_CO && addr == CO_LAST)) begin
                        addr_nxt  = '0;
                        state_nxt = (state == S_READ_R) ? S_WAIT_CO : S_WAIT_IN;
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
                InReady  = 1'b1;
                addr_nxt = '0;
                if (clear_req)
                    state_nxt = S_CLEAR;
                else if (Frame_sync)
                    state_nxt = S_WORK;
            end
            S_WORK: begin
                InReady = 1'b1;
                if (pulse) begin
                    // A non-zero sample wakes a sleeping channel and is processed in the same pulse
                    if (!(cur_sleep && cur_zero)) begin
                        mem_In_en = 1'b1;
                        mem_r0w1  = 1'b1;
                        ALU_calc  = 1'b1;
                        alu_ch    = ch_ptr;
                    end
                    addr_nxt = (addr == IN_LAST) ? '0 : addr + 1'b1;
                end else begin
                    {mem_R_en, mem_Co_en, mem_In_en} = 3'b111;
                end
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                    addr_nxt  = '0;
                end
            end
            S_CLEAR: begin
                mem_In_en      = 1'b1;
                mem_r0w1       = 1'b1;
                mem_clear_data = 1'b1;
                if (addr == IN_LAST) begin
                    state_nxt = S_WAIT_IN;
                    addr_nxt  = '0;
                    clr_ch    = 1'b1;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Start restarts everything; channel state goes too since input memory is re-zeroed
        if (Start) begin
            state_nxt = S_INIT;
            addr_nxt  = '0;
            clr_ch    = 1'b1;
        end
    end

    always_ff @(posedge Sclk) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            ch_ptr   <= '0;
            in_d     <= 1'b0;
            load_err <= 1'b0;
            sleep    <= '0;
            for (int unsigned c = 0; c < N_CH; c++) zcnt[c] <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            in_d  <= in_data_ready;
            if (Start)
                load_err <= 1'b0;
            else if (abort)
                load_err <= 1'b1;
            if (clr_ch)
                ch_ptr <= '0;
            else if (pulse_work)
                ch_ptr <= (ch_ptr == CH_LAST) ? '0 : ch_ptr + 1'b1;
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (clr_ch) begin
                    zcnt[c]  <= '0;
                    sleep[c] <= 1'b0;
                end else if (pulse_work && CW'(c) == ch_ptr) begin
                    if (all_zero[c]) begin
                        if (zcnt[c] != Z_MAX) zcnt[c] <= zcnt[c] + 1'b1;
                        else                  sleep[c] <= 1'b1;
                    end else begin
                        zcnt[c]  <= '0;
                        sleep[c] <= 1'b0;
                    end
                end else if (zcnt[c] == Z_MAX) begin
                    sleep[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_main_ctrl_mc.sv
// Directed, table-driven bench for main_ctrl_mc with default parameters.
module tb_main_ctrl_mc;

    logic       Sclk = 1'b0;
    logic       Reset_n, Start, Frame_sync, in_data_ready, clear_req;
    logic [1:0] all_zero;
    logic       InReady, ALU_calc, alu_ch, mem_clear_data;
    logic       mem_R_en, mem_Co_en, mem_In_en, mem_r0w1, load_err;
    logic [9:0] mem_addr;
    logic [1:0] sleep;

    main_ctrl_mc #(.N_CH(2), .R_DEPTH(16), .CO_DEPTH(512), .IN_DEPTH(256),
                   .ZERO_LIMIT(800), .AW(10), .CW(1)) dut (
        .Sclk(Sclk), .Reset_n(Reset_n), .Start(Start), .Frame_sync(Frame_sync),
        .in_data_ready(in_data_ready), .all_zero(all_zero), .clear_req(clear_req),
        .InReady(InReady), .ALU_calc(ALU_calc), .alu_ch(alu_ch),
        .mem_clear_data(mem_clear_data), .mem_R_en(mem_R_en), .mem_Co_en(mem_Co_en),
        .mem_In_en(mem_In_en), .mem_r0w1(mem_r0w1), .mem_addr(mem_addr),
        .sleep(sleep), .load_err(load_err));

    always #5 Sclk = ~Sclk;

    typedef struct {
        logic        rst_n, start, fs, idr, clr;
        logic [1:0]  az;
        logic [20:0] exp;
    } vec_t;

    int n_pass = 0, n_total = 0;
    int waddr = 0, p = 0;
    int a511 = -1, a512 = -1;
    vec_t tbl1[6];
    vec_t tbl2[7];

    function automatic logic [20:0] mk(input logic ir, alu, ch, cd, r, co, inn, w,
                                       input logic [1:0] slp, input logic le, input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {ir, alu, ch, cd, r, co, inn, w, slp, le, a10};
    endfunction

    function automatic vec_t mkv(input logic rst_n, start, fs, idr, clr,
                                 input logic [1:0] az, input logic [20:0] e);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.fs = fs; v.idr = idr; v.clr = clr;
        v.az = az; v.exp = e;
        return v;
    endfunction

    function automatic logic [20:0] outs();
        return {InReady, ALU_calc, alu_ch, mem_clear_data, mem_R_en, mem_Co_en,
                mem_In_en, mem_r0w1, sleep, load_err, mem_addr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge Sclk); #1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag, input int idx);
        Reset_n = v.rst_n; Start = v.start; Frame_sync = v.fs;
        in_data_ready = v.idr; clear_req = v.clr; all_zero = v.az;
        #2;
        chk($sformatf("%s_%0d", tag, idx), 32'(outs()), 32'(v.exp));
        cyc();
    endtask

    task automatic do_pulse(input logic [1:0] az, output logic [20:0] o);
        all_zero = az;
        in_data_ready = 1'b1;
        #2;
        o = outs();
        cyc();
        in_data_ready = 1'b0;
        cyc();
    endtask

    // Counts consecutive clear_data cycles from the current (settled) cycle
    task automatic count_phase(input logic exp_rco, output int n, output int seq_err,
                               output int en_err);
        n = 0; seq_err = 0; en_err = 0;
        while (mem_clear_data === 1'b1 && n < 3000) begin
            if (mem_addr !== n[9:0]) seq_err++;
            if ({mem_R_en, mem_Co_en} !== {2{exp_rco}} || mem_In_en !== 1'b1 ||
                mem_r0w1 !== 1'b1 || InReady !== 1'b0) en_err++;
            n++;
            cyc(); #2;
        end
    endtask

    task automatic full_load();
        logic [20:0] o;
        int e;
        Frame_sync = 1'b1; cyc(); Frame_sync = 1'b0;
        e = 0;
        for (int i = 0; i < 32; i++) begin
            do_pulse(2'b00, o);
            if (o !== mk(1,0,0,0,1,0,0,1,2'b00,0,i)) e++;
        end
        chk("r_load_seq", e, 0);
        #2; chk("wait_co", 32'(outs()), 32'(mk(1,0,0,0,0,0,0,0,2'b00,0,0)));
        Frame_sync = 1'b1; cyc(); Frame_sync = 1'b0;
        e = 0;
        for (int i = 0; i < 1024; i++) begin
            do_pulse(2'b00, o);
            if (o !== mk(1,0,0,0,0,1,0,1,2'b00,0,i)) e++;
        end
        chk("co_load_seq", e, 0);
        #2; chk("wait_in", 32'(outs()), 32'(mk(1,0,0,0,0,0,0,0,2'b00,0,0)));
    endtask

    task automatic wpulse(input logic [1:0] az, input logic e_alu, input logic e_ch,
                          input logic [1:0] e_slp, output int bad);
        logic [20:0] o, e;
        do_pulse(az, o);
        e = e_alu ? mk(1,1,e_ch,0,0,0,1,1,e_slp,0,waddr)
                  : mk(1,0,0,0,0,0,0,0,e_slp,0,waddr);
        bad = (o !== e) ? 1 : 0;
        if (p == 511) a511 = int'(o[9:0]);
        if (p == 512) a512 = int'(o[9:0]);
        waddr = (waddr + 1) % 512;
        p++;
    endtask

    initial begin
        logic [20:0] o;
        int n, se, ee, e, b;

        tbl1[0] = mkv(0,1,0,0,0,2'b00, mk(0,0,0,0,0,0,0,0,2'b00,0,0));
        tbl1[1] = mkv(1,0,0,0,0,2'b00, mk(0,0,0,0,0,0,0,0,2'b00,0,0));
        tbl1[2] = mkv(1,1,0,0,0,2'b00, mk(0,0,0,0,0,0,0,0,2'b00,0,0));
        tbl1[3] = mkv(1,0,0,0,0,2'b00, mk(0,0,0,1,1,1,1,1,2'b00,0,0));
        tbl1[4] = mkv(1,0,0,0,0,2'b00, mk(0,0,0,1,1,1,1,1,2'b00,0,1));
        tbl1[5] = mkv(1,1,0,0,0,2'b00, mk(0,0,0,1,1,1,1,1,2'b00,0,2));
        tbl2[0] = mkv(1,0,1,0,0,2'b00, mk(1,0,0,0,0,0,0,0,2'b00,0,0));
        tbl2[1] = mkv(1,0,0,0,1,2'b00, mk(1,0,0,0,0,0,0,0,2'b00,0,0));
        tbl2[2] = mkv(1,0,0,1,0,2'b00, mk(1,0,0,0,1,0,0,1,2'b00,0,0));
        tbl2[3] = mkv(1,0,0,1,0,2'b00, mk(1,0,0,0,0,0,0,0,2'b00,0,1));
        tbl2[4] = mkv(1,0,0,0,0,2'b00, mk(1,0,0,0,0,0,0,0,2'b00,0,1));
        tbl2[5] = mkv(1,0,0,1,0,2'b00, mk(1,0,0,0,1,0,0,1,2'b00,0,1));
        tbl2[6] = mkv(1,0,0,0,0,2'b00, mk(1,0,0,0,0,0,0,0,2'b00,0,2));

        Reset_n = 1'b0; Start = 1'b1; Frame_sync = 1'b0; in_data_ready = 1'b0;
        clear_req = 1'b0; all_zero = 2'b00;
        repeat (3) @(posedge Sclk);
        #1;

        // Reset, Start, INIT restart
        for (int i = 0; i < 6; i++) apply_vec(tbl1[i], "rst_init", i);
        Start = 1'b0;
        #2;
        count_phase(1'b1, n, se, ee);
        chk("init_len", n, 1024);
        chk("init_addr_seq", se, 0);
        chk("init_enables", ee, 0);

        // R load start, clear_req ignored in READ_R, then abort after 10 words
        for (int i = 0; i < 7; i++) apply_vec(tbl2[i], "read_r", i);
        e = 0;
        for (int i = 2; i < 10; i++) begin
            do_pulse(2'b00, o);
            if (o !== mk(1,0,0,0,1,0,0,1,2'b00,0,i)) e++;
        end
        chk("r_partial_seq", e, 0);
        Frame_sync = 1'b1; #2;
        chk("abort_cycle", 32'(outs()), 32'(mk(1,0,0,0,0,0,0,0,2'b00,0,10)));
        cyc(); Frame_sync = 1'b0; #2;
        chk("abort_state", 32'(outs()), 32'(mk(1,0,0,0,0,0,0,0,2'b00,1,0)));
        Frame_sync = 1'b1; cyc(); Frame_sync = 1'b0;
        do_pulse(2'b00, o);
        chk("reload_r_addr0", 32'(o), 32'(mk(1,0,0,0,1,0,0,1,2'b00,1,0)));

        // Start clears load_err and reruns INIT, then full load
        Start = 1'b1; cyc(); Start = 1'b0; #2;
        chk("start_clears_err", 32'(outs()), 32'(mk(0,0,0,1,1,1,1,1,2'b00,0,0)));
        count_phase(1'b1, n, se, ee);
        chk("init2_len", n, 1024);
        full_load();

        // WORK: ch1 goes to sleep after 800 zero samples
        Frame_sync = 1'b1; cyc(); Frame_sync = 1'b0; #2;
        chk("work_idle", 32'(outs()), 32'(mk(1,0,0,0,1,1,1,0,2'b00,0,0)));
        e = 0;
        for (int k = 0; k < 800; k++) begin
            wpulse(2'b10, 1, 0, 2'b00, b); e += b;
            wpulse(2'b10, 1, 1, 2'b00, b); e += b;
        end
        chk("work_awake_seq", e, 0);
        chk("addr_before_wrap", a511, 511);
        chk("addr_wrap", a512, 0);
        chk("sleep_set", 32'(sleep), 32'(2'b10));
        e = 0;
        for (int k = 0; k < 3; k++) begin
            wpulse(2'b10, 1, 0, 2'b10, b); e += b;
            wpulse(2'b10, 0, 0, 2'b10, b); e += b;
        end
        chk("sleep_pulses", e, 0);
        wpulse(2'b00, 1, 0, 2'b10, b);
        chk("ch0_while_ch1_sleeps", b, 0);
        wpulse(2'b00, 1, 1, 2'b10, b);
        chk("wake_same_pulse", b, 0);
        chk("wake_clear", 32'(sleep), 32'(2'b00));
        wpulse(2'b00, 1, 0, 2'b00, b);
        chk("after_wake", b, 0);

        // Soft clear with ch_ptr at 1; must return to ch0, addr 0
        clear_req = 1'b1; cyc(); clear_req = 1'b0; #2;
        count_phase(1'b0, n, se, ee);
        chk("clear_len", n, 512);
        chk("clear_addr_seq", se, 0);
        chk("clear_no_r_co", ee, 0);
        chk("clear_exit", 32'(outs()), 32'(mk(1,0,0,0,0,0,0,0,2'b00,0,0)));
        Frame_sync = 1'b1; cyc(); Frame_sync = 1'b0;
        do_pulse(2'b00, o);
        chk("post_clear_ch", 32'(o), 32'(mk(1,1,0,0,0,0,1,1,2'b00,0,0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
